// File: rtl/onchip_mem_pkg.sv
// Shared constants and configuration helpers for the on-chip memory family.
package onchip_mem_pkg;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nbytes(input int unsigned width);
        return width / BYTE_W;
    endfunction

    function automatic bit width_ok(input int unsigned width);
        return (width > 0) && ((width % BYTE_W) == 0);
    endfunction

    function automatic bit latency_ok(input int unsigned lat);
        return (lat == 1) || (lat == 2);
    endfunction

endpackage

// File: rtl/onchip_rd_pipe.sv
// Read-return pipeline: delays the read qualifier and the sampled word by
// READ_LATENCY enabled cycles, then registers them onto the port outputs.
module onchip_rd_pipe
    import onchip_mem_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  rd_accept,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid
);

    localparam int unsigned LAT    = READ_LATENCY;
    localparam int unsigned DAT_W  = LAT * DATA_WIDTH;

    logic [LAT-1:0]   vld_q;
    logic [DAT_W-1:0] dat_q;
    logic [LAT-1:0]   vld_d;
    logic [DAT_W-1:0] dat_d;

    // Stage 0 takes the new sample; older stages shift toward the tap.
    assign vld_d = LAT'({vld_q, rd_accept});
    assign dat_d = DAT_W'({dat_q, rd_data});

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q         <= '0;
            dat_q         <= '0;
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else if (clken) begin
            vld_q         <= vld_d;
            dat_q         <= dat_d;
            readdatavalid <= vld_q[LAT-1];
            if (vld_q[LAT-1]) begin
                readdata <= dat_q[DAT_W-1 -: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/onchip_ram_dp.sv
// Dual-port Avalon-MM on-chip RAM/ROM with configurable width, depth and
// read latency; s1 wins same-address write collisions.
module onchip_ram_dp
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          WRITABLE     = 1'b1,
    parameter string       INIT_FILE    = "onchip_ram_dp.hex"
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            clken,
    output logic                            collision,

    input  logic [ADDR_WIDTH-1:0]           s1_address,
    input  logic                            s1_chipselect,
    input  logic                            s1_read,
    input  logic                            s1_write,
    input  logic [nbytes(DATA_WIDTH)-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]           s1_writedata,
    output logic [DATA_WIDTH-1:0]           s1_readdata,
    output logic                            s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]           s2_address,
    input  logic                            s2_chipselect,
    input  logic                            s2_read,
    input  logic                            s2_write,
    input  logic [nbytes(DATA_WIDTH)-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]           s2_writedata,
    output logic [DATA_WIDTH-1:0]           s2_readdata,
    output logic                            s2_readdatavalid
);

    localparam int unsigned NB    = nbytes(DATA_WIDTH);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (!width_ok(DATA_WIDTH) || !latency_ok(READ_LATENCY)) begin : g_bad_cfg
        $error("onchip_ram_dp: DATA_WIDTH must be a byte multiple and READ_LATENCY 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic s1_rd_acc;
    logic s1_wr_acc;
    logic s2_rd_acc;
    logic s2_wr_acc;
    logic wr_clash;

    // Write has precedence, so a read+write request is only a write.
    assign s1_wr_acc = s1_chipselect & s1_write;
    assign s1_rd_acc = s1_chipselect & s1_read & ~s1_write;
    assign s2_wr_acc = s2_chipselect & s2_write;
    assign s2_rd_acc = s2_chipselect & s2_read & ~s2_write;
    assign wr_clash  = s1_wr_acc & s2_wr_acc & (s1_address == s2_address);

    logic [DATA_WIDTH-1:0] s1_mask;
    logic [DATA_WIDTH-1:0] s2_mask;

    for (genvar b = 0; b < NB; b++) begin : g_lane
        assign s1_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{s1_byteenable[b]}};
        assign s2_mask[b*BYTE_W +: BYTE_W] = {BYTE_W{s2_byteenable[b]}};
    end

    // Byte-lane merge; on a clash the whole s2 write is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && clken && WRITABLE) begin
            if (s1_wr_acc) begin
                mem[s1_address] <= (mem[s1_address] & ~s1_mask) | (s1_writedata & s1_mask);
            end
            if (s2_wr_acc && !wr_clash) begin
                mem[s2_address] <= (mem[s2_address] & ~s2_mask) | (s2_writedata & s2_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            collision <= 1'b0;
        end else if (clken) begin
            collision <= wr_clash;
        end
    end

    // Sampling pre-edge contents gives cross-port reads the old data.
    logic [DATA_WIDTH-1:0] s1_rd_data;
    logic [DATA_WIDTH-1:0] s2_rd_data;

    assign s1_rd_data = mem[s1_address];
    assign s2_rd_data = mem[s2_address];

    onchip_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_s1_pipe (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .rd_accept     (s1_rd_acc),
        .rd_data       (s1_rd_data),
        .readdata      (s1_readdata),
        .readdatavalid (s1_readdatavalid)
    );

    onchip_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_s2_pipe (
        .clk           (clk),
        .reset_n       (reset_n),
        .clken         (clken),
        .rd_accept     (s2_rd_acc),
        .rd_data       (s2_rd_data),
        .readdata      (s2_readdata),
        .readdatavalid (s2_readdatavalid)
    );

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Bench for onchip_ram_dp: three instances (latency 1, latency 2, ROM) share
// one stimulus stream and are checked every cycle against a transaction model.
module tb_onchip_ram_dp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          clken;
    logic [AW-1:0] s1_address,    s2_address;
    logic          s1_chipselect, s2_chipselect;
    logic          s1_read,       s2_read;
    logic          s1_write,      s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata,  s2_writedata;

    logic [DW-1:0] rdata  [NI][2];
    logic          rvalid [NI][2];
    logic          coll   [NI];

    onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITABLE(1'b1), .INIT_FILE("")) u_lat1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .collision(coll[0]),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata[0][0]), .s1_readdatavalid(rvalid[0][0]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata[0][1]), .s2_readdatavalid(rvalid[0][1])
    );

    onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITABLE(1'b1), .INIT_FILE("")) u_lat2 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .collision(coll[1]),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata[1][0]), .s1_readdatavalid(rvalid[1][0]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata[1][1]), .s2_readdatavalid(rvalid[1][1])
    );

    onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITABLE(1'b0), .INIT_FILE("")) u_rom (
        .clk(clk), .reset_n(reset_n), .clken(clken), .collision(coll[2]),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdata[2][0]), .s1_readdatavalid(rvalid[2][0]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
        .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdata[2][1]), .s2_readdatavalid(rvalid[2][1])
    );

    // Reference model: word array for the writable instances, plus per
    // instance/port a schedule of returns keyed by enabled-cycle number.
    logic [DW-1:0] mdl_mem [64];
    int unsigned   ecount;
    bit            due_v [NI][2][4];
    logic [DW-1:0] due_d [NI][2][4];
    bit            exp_v [NI][2];
    logic [DW-1:0] exp_d [NI][2];
    bit            exp_known [NI][2];
    bit            exp_c;

    int checks = 0;
    int errors = 0;

    function automatic int unsigned lat_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic model_edge();
        bit rd1, rd2, w1, w2;
        logic [DW-1:0] old1, old2;
        int unsigned slot;
        if (!reset_n) begin
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < 2; p++) begin
                    for (int s = 0; s < 4; s++) due_v[i][p][s] = 1'b0;
                    exp_v[i][p] = 1'b0;
                    exp_d[i][p] = '0;
                    exp_known[i][p] = 1'b1;
                end
            exp_c = 1'b0;
        end else if (clken) begin
            ecount++;
            slot = ecount % 4;
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < 2; p++) begin
                    if (due_v[i][p][slot]) begin
                        exp_v[i][p] = 1'b1;
                        exp_d[i][p] = due_d[i][p][slot];
                        exp_known[i][p] = (i != 2);
                        due_v[i][p][slot] = 1'b0;
                    end else begin
                        exp_v[i][p] = 1'b0;
                    end
                end
            w1   = s1_chipselect && s1_write;
            w2   = s2_chipselect && s2_write;
            rd1  = s1_chipselect && s1_read && !s1_write;
            rd2  = s2_chipselect && s2_read && !s2_write;
            old1 = mdl_mem[s1_address[5:0]];
            old2 = mdl_mem[s2_address[5:0]];
            for (int i = 0; i < NI; i++) begin
                if (rd1) begin
                    due_v[i][0][(ecount + lat_of(i)) % 4] = 1'b1;
                    due_d[i][0][(ecount + lat_of(i)) % 4] = old1;
                end
                if (rd2) begin
                    due_v[i][1][(ecount + lat_of(i)) % 4] = 1'b1;
                    due_d[i][1][(ecount + lat_of(i)) % 4] = old2;
                end
            end
            exp_c = w1 && w2 && (s1_address == s2_address);
            if (w1) mdl_mem[s1_address[5:0]] = merge(mdl_mem[s1_address[5:0]], s1_writedata, s1_byteenable);
            if (w2 && !exp_c) mdl_mem[s2_address[5:0]] = merge(mdl_mem[s2_address[5:0]], s2_writedata, s2_byteenable);
        end
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rdv_i%0d_s%0d", i, p + 1), DW'(rvalid[i][p]), DW'(exp_v[i][p]));
                if (exp_known[i][p]) chk($sformatf("rdata_i%0d_s%0d", i, p + 1), rdata[i][p], exp_d[i][p]);
            end
            chk($sformatf("collision_i%0d", i), DW'(coll[i]), DW'(exp_c));
        end
    endtask

    task automatic req(input int p, input bit cs, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        if (p == 1) begin
            s1_chipselect = cs; s1_read = rd; s1_write = wr;
            s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = cs; s2_read = rd; s2_write = wr;
            s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
    endtask

    task automatic idle();
        req(1, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
        req(2, 1'b0, 1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    task automatic rand_port(input int p);
        int unsigned op;
        op = $urandom_range(0, 4);
        req(p, op != 4, (op == 1) || (op >= 3), (op == 2) || (op >= 3),
            AW'($urandom_range(0, 7)), DW'($urandom), 4'($urandom));
    endtask

    int cnt;

    initial begin
        ecount = 0;
        for (int a = 0; a < 64; a++) mdl_mem[a] = '0;
        idle();
        reset_n = 1'b0;
        clken   = 1'b1;

        // Reset and idle
        repeat (3) cycle();
        reset_n = 1'b1;
        cycle();
        for (int i = 0; i < NI; i++) begin
            chk("rst_s1_readdata", rdata[i][0], '0);
            chk("rst_s2_readdata", rdata[i][1], '0);
            chk("rst_collision", DW'(coll[i]), '0);
        end

        // Preload the low words used below
        for (int a = 0; a < 64; a++) begin
            req(1, 1'b1, 1'b0, 1'b1, AW'(a), DW'($urandom), 4'hF);
            cycle();
        end
        idle();

        // Basic write on s1, read on s2 one cycle later
        req(1, 1'b1, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        cycle();
        idle();
        req(2, 1'b1, 1'b1, 1'b0, 16'h0010, '0, 4'h0);
        cycle();
        idle();
        cycle();
        chk("basic_rdv", DW'(rvalid[0][1]), 32'd1);
        chk("basic_rdata", rdata[0][1], 32'hDEADBEEF);
        chk("rom_basic_unwritten", DW'(rdata[2][1] !== 32'hDEADBEEF), 32'd1);

        // Byte-lane write from s2
        req(2, 1'b1, 1'b0, 1'b1, 16'h0010, 32'h11223344, 4'h5);
        cycle();
        idle();
        req(1, 1'b1, 1'b1, 1'b0, 16'h0010, '0, 4'h0);
        cycle();
        idle();
        cycle();
        chk("lane_rdata", rdata[0][0], 32'hDE22BE44);
        chk("rom_lane_unwritten", DW'(rdata[2][0] !== 32'hDE22BE44), 32'd1);

        // Same-address write collision
        req(1, 1'b1, 1'b0, 1'b1, 16'h0020, 32'hAAAAAAAA, 4'hF);
        req(2, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h55555555, 4'hF);
        cycle();
        idle();
        chk("coll_pulse", DW'(coll[0]), 32'd1);
        chk("coll_pulse_rom", DW'(coll[2]), 32'd1);
        req(1, 1'b1, 1'b1, 1'b0, 16'h0020, '0, 4'h0);
        cycle();
        idle();
        chk("coll_clear", DW'(coll[0]), 32'd0);
        cycle();
        chk("coll_winner", rdata[0][0], 32'hAAAAAAAA);

        // Cross-port read during write returns the old word
        req(1, 1'b1, 1'b0, 1'b1, 16'h0020, 32'h12345678, 4'hF);
        req(2, 1'b1, 1'b1, 1'b0, 16'h0020, '0, 4'h0);
        cycle();
        idle();
        cycle();
        chk("rdw_old", rdata[0][1], 32'hAAAAAAAA);

        // Back-to-back reads, latency 2 instance
        cnt = 0;
        for (int a = 0; a < 4; a++) begin
            req(1, 1'b1, 1'b1, 1'b0, AW'(a), '0, 4'h0);
            cycle();
            if (rvalid[1][0]) cnt++;
        end
        idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (rvalid[1][0]) cnt++;
        end
        chk("lat2_burst_count", DW'(cnt), 32'd4);

        // Clock enable stall after a read accept
        req(2, 1'b1, 1'b1, 1'b0, 16'h0010, '0, 4'h0);
        cycle();
        idle();
        clken = 1'b0;
        repeat (3) cycle();
        chk("stall_no_rdv", DW'(rvalid[0][1]), 32'd0);
        clken = 1'b1;
        cycle();
        chk("stall_rdv", DW'(rvalid[0][1]), 32'd1);
        chk("stall_rdata", rdata[0][1], 32'hDE22BE44);
        cycle();

        // Reset one cycle after a read accept kills the read
        req(1, 1'b1, 1'b1, 1'b0, 16'h0010, '0, 4'h0);
        cycle();
        idle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (rvalid[0][0] || rvalid[1][0]) cnt++;
        end
        chk("rst_kills_read", DW'(cnt), 32'd0);

        // Randomised traffic on a narrow address window
        for (int n = 0; n < 400; n++) begin
            clken   = ($urandom_range(0, 7) != 0);
            reset_n = ($urandom_range(0, 149) != 0);
            rand_port(1);
            rand_port(2);
            cycle();
        end
        reset_n = 1'b1;
        clken   = 1'b1;
        idle();
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
